fft_frame_sequencer: RTL and testbench

//  Frame-level controller in front of the radix-2 SDF FFT stage chain (N=2^LOG2N points).

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_out_framer.sv | 100 ++++++++++
 rtl/fft_frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: default transform size,
// input-side FSM state encoding and the bit-reverse helper used for bin indices.
package fft_pkg;

    localparam int FFT_LOG2N = 12;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP
    } in_state_t;

    // Number of points for a given log2 length.
    function automatic int fft_points(input int log2n);
        return 1 << log2n;
    endfunction

    // Reverse the low 'bits' bits of v; higher bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits) begin
                r[i] = v[5'(bits - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_framer.sv
// Output framer: after a pipe_start it waits OUT_OFFSET cycles, then opens an
// N-cycle window in which the last-stage data is registered onto m_* together
// with first/last markers and the bit-reversed bin index.
module fft_out_framer
    import fft_pkg::*;
#(
    parameter int LOG2N      = FFT_LOG2N,
    parameter int DW         = 32,
    parameter int OUT_OFFSET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_start,
    input  logic [DW-1:0]    pipe_real,
    input  logic [DW-1:0]    pipe_img,
    output logic             m_valid,
    output logic             m_first,
    output logic             m_last,
    output logic [DW-1:0]    m_real,
    output logic [DW-1:0]    m_img,
    output logic [LOG2N-1:0] m_index,
    output logic             overlap_err,
    output logic             last_set
);

    localparam int N     = fft_points(LOG2N);
    localparam int SPAN  = OUT_OFFSET + N;
    localparam int POS_W = $clog2(SPAN + 1);
    localparam logic [POS_W-1:0] OFF      = POS_W'(OUT_OFFSET);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(SPAN - 1);

    logic             busy;
    logic [POS_W-1:0] pos;
    logic             cur_busy;
    logic [POS_W-1:0] cur_pos;
    logic             past_off;
    logic             in_win;
    logic [LOG2N-1:0] k;

    // A fresh pipe_start always restarts the sequence at position 0.
    always_comb begin
        cur_busy = pipe_start | busy;
        cur_pos  = pipe_start ? '0 : pos;
    end

    if (OUT_OFFSET == 0) begin : g_no_offset
        assign past_off = 1'b1;
    end else begin : g_offset
        assign past_off = (cur_pos >= OFF);
    end

    // Window position k and the end-of-frame event used by the inflight counter.
    always_comb begin
        in_win   = cur_busy && past_off;
        k        = LOG2N'(cur_pos - OFF);
        last_set = in_win && (k == '1);
    end

    // Offset/window position tracking plus the sticky overlap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            pos         <= '0;
            overlap_err <= 1'b0;
        end else begin
            if (pipe_start && busy) begin
                overlap_err <= 1'b1;
            end
            if (cur_busy) begin
                if (cur_pos == POS_LAST) begin
                    busy <= 1'b0;
                    pos  <= '0;
                end else begin
                    busy <= 1'b1;
                    pos  <= cur_pos + 1'b1;
                end
            end
        end
    end

    // Registered output stream; everything is zero outside the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            m_real  <= '0;
            m_img   <= '0;
            m_index <= '0;
        end else begin
            m_valid <= in_win;
            m_first <= in_win && (k == '0);
            m_last  <= last_set;
            m_real  <= in_win ? pipe_real : '0;
            m_img   <= in_win ? pipe_img : '0;
            m_index <= in_win ? LOG2N'(bitrev(32'(k), LOG2N)) : '0;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller ahead of the SDF FFT chain: builds gap-free input
// frames with start/over markers, enforces the inter-frame halt, limits the
// number of frames in flight and frames the FFT output stream.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N        = FFT_LOG2N,
    parameter int DW           = 32,
    parameter int GAP_CYCLES   = 6,
    parameter int OUT_OFFSET   = 0,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_real,
    input  logic [DW-1:0]    s_img,
    output logic             fft_start,
    output logic             fft_over,
    output logic [DW-1:0]    fft_real,
    output logic [DW-1:0]    fft_img,
    input  logic             pipe_start,
    input  logic [DW-1:0]    pipe_real,
    input  logic [DW-1:0]    pipe_img,
    output logic             m_valid,
    output logic             m_first,
    output logic             m_last,
    output logic [DW-1:0]    m_real,
    output logic [DW-1:0]    m_img,
    output logic [LOG2N-1:0] m_index,
    output logic             underrun,
    output logic             overlap_err,
    output logic [LOG2N:0]   inflight
);

    localparam int IW    = LOG2N + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]    MAX_IF   = IW'(MAX_INFLIGHT);

    in_state_t        state;
    logic [LOG2N-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             start_set;
    logic             last_set;

    // Acceptance is gated by the inflight limit only while waiting for a new frame.
    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    s_ready = (inflight < MAX_IF);
                RUN:     s_ready = 1'b1;
                default: s_ready = 1'b0;
            endcase
        end
        start_set = (state == IDLE) && s_valid && s_ready;
    end

    // Input FSM: one registered sample per cycle in RUN, zero-filled on underrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gap_cnt   <= '0;
            fft_start <= 1'b0;
            fft_over  <= 1'b0;
            fft_real  <= '0;
            fft_img   <= '0;
            underrun  <= 1'b0;
        end else begin
            fft_start <= 1'b0;
            fft_over  <= 1'b0;
            fft_real  <= '0;
            fft_img   <= '0;
            underrun  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_set) begin
                        fft_start <= 1'b1;
                        fft_real  <= s_real;
                        fft_img   <= s_img;
                        cnt       <= LOG2N'(1);
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (s_valid) begin
                        fft_real <= s_real;
                        fft_img  <= s_img;
                    end else begin
                        underrun <= 1'b1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        fft_over <= 1'b1;
                        cnt      <= '0;
                        gap_cnt  <= '0;
                        state    <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Frames in flight: up on a new frame, down on its last output bin.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({start_set, last_set})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= (inflight == '0) ? '0 : inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    fft_out_framer #(
        .LOG2N      (LOG2N),
        .DW         (DW),
        .OUT_OFFSET (OUT_OFFSET)
    ) u_out_framer (
        .clk         (clk),
        .rst         (rst),
        .pipe_start  (pipe_start),
        .pipe_real   (pipe_real),
        .pipe_img    (pipe_img),
        .m_valid     (m_valid),
        .m_first     (m_first),
        .m_last      (m_last),
        .m_real      (m_real),
        .m_img       (m_img),
        .m_index     (m_index),
        .overlap_err (overlap_err),
        .last_set    (last_set)
    );

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer at N=8, GAP_CYCLES=2, OUT_OFFSET=1,
// MAX_INFLIGHT=2. Inputs change 1ns after each rising edge and outputs are
// checked at that same point.
module tb_fft_frame_sequencer;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_real = '0;
    logic [DW-1:0] s_img = '0;
    logic          fft_start;
    logic          fft_over;
    logic [DW-1:0] fft_real;
    logic [DW-1:0] fft_img;
    logic          pipe_start = 1'b0;
    logic [DW-1:0] pipe_real = '0;
    logic [DW-1:0] pipe_img = '0;
    logic          m_valid;
    logic          m_first;
    logic          m_last;
    logic [DW-1:0] m_real;
    logic [DW-1:0] m_img;
    logic [2:0]    m_index;
    logic          underrun;
    logic          overlap_err;
    logic [3:0]    inflight;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] brev_tab [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    fft_frame_sequencer #(
        .LOG2N        (3),
        .DW           (DW),
        .GAP_CYCLES   (2),
        .OUT_OFFSET   (1),
        .MAX_INFLIGHT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_real      (s_real),
        .s_img       (s_img),
        .fft_start   (fft_start),
        .fft_over    (fft_over),
        .fft_real    (fft_real),
        .fft_img     (fft_img),
        .pipe_start  (pipe_start),
        .pipe_real   (pipe_real),
        .pipe_img    (pipe_img),
        .m_valid     (m_valid),
        .m_first     (m_first),
        .m_last      (m_last),
        .m_real      (m_real),
        .m_img       (m_img),
        .m_index     (m_index),
        .underrun    (underrun),
        .overlap_err (overlap_err),
        .inflight    (inflight)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then step to 1ns after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic ps, input logic [DW-1:0] pr);
        s_valid    = v;
        s_real     = d;
        s_img      = d + 16'd100;
        pipe_start = ps;
        pipe_real  = pr;
        pipe_img   = pr + 16'd200;
        @(posedge clk);
        #1;
    endtask

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;

        // Reset state
        applyStimulus(1'b0, '0, 1'b0, '0);
        applyStimulus(1'b1, 16'h7, 1'b0, '0);
        checkOutput("rst_fft_start", 32'(fft_start), 32'd0);
        checkOutput("rst_fft_real", 32'(fft_real), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_inflight", 32'(inflight), 32'd0);
        checkOutput("rst_overlap", 32'(overlap_err), 32'd0);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("idle_s_ready", 32'(s_ready), 32'd1);

        // Scenario 1: continuous frame 1..8, then a 2-cycle halt
        $display("[TB] scenario 1: continuous frame");
        applyStimulus(1'b1, 16'd1, 1'b0, '0);
        checkOutput("f1_start", 32'(fft_start), 32'd1);
        checkOutput("f1_real0", 32'(fft_real), 32'd1);
        checkOutput("f1_img0", 32'(fft_img), 32'd101);
        checkOutput("f1_inflight", 32'(inflight), 32'd1);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0, '0);
            checkOutput("f1_real", 32'(fft_real), 32'(i));
            checkOutput("f1_start_low", 32'(fft_start), 32'd0);
            checkOutput("f1_over", 32'(fft_over), 32'(i == 8));
        end
        checkOutput("f1_gap_ready0", 32'(s_ready), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("f1_gap_ready1", 32'(s_ready), 32'd0);
        checkOutput("f1_gap_zero", 32'(fft_real), 32'd0);
        checkOutput("f1_gap_over", 32'(fft_over), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0);
        checkOutput("f1_idle_ready", 32'(s_ready), 32'd1);

        // Scenario 2: s_valid dropped at the 4th slot
        $display("[TB] scenario 2: underrun");
        for (int slot = 0; slot < 8; slot++) begin
            d     = (slot < 3) ? DW'(slot + 1) : ((slot == 3) ? 16'h55 : DW'(slot));
            exp_d = (slot == 3) ? '0 : d;
            applyStimulus(slot != 3, d, 1'b0, '0);
            checkOutput("f2_real", 32'(fft_real), 32'(exp_d));
            checkOutput("f2_img", 32'(fft_img), (slot == 3) ? 32'd0 : 32'(d + 16'd100));
            checkOutput("f2_underrun", 32'(underrun), 32'(slot == 3));
            checkOutput("f2_start", 32'(fft_start), 32'(slot == 0));
            checkOutput("f2_over", 32'(fft_over), 32'(slot == 7));
        end
        checkOutput("f2_inflight", 32'(inflight), 32'd2);
        applyStimulus(1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0);

        // Scenario 4 (hold): third frame waits while two are in flight
        $display("[TB] scenario 4: inflight limit");
        for (int i = 0; i < 3; i++) begin
            checkOutput("f3_hold_ready", 32'(s_ready), 32'd0);
            applyStimulus(1'b1, 16'd9, 1'b0, '0);
            checkOutput("f3_hold_start", 32'(fft_start), 32'd0);
        end

        // Scenario 3: output window with ramp 0..7
        $display("[TB] scenario 3: output window");
        applyStimulus(1'b1, 16'd9, 1'b1, 16'h99);
        checkOutput("w1_offset_valid", 32'(m_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 16'd9, 1'b0, DW'(k));
            checkOutput("w1_valid", 32'(m_valid), 32'd1);
            checkOutput("w1_real", 32'(m_real), 32'(k));
            checkOutput("w1_img", 32'(m_img), 32'(k + 200));
            checkOutput("w1_index", 32'(m_index), 32'(brev_tab[k]));
            checkOutput("w1_first", 32'(m_first), 32'(k == 0));
            checkOutput("w1_last", 32'(m_last), 32'(k == 7));
            checkOutput("w1_no_start", 32'(fft_start), 32'd0);
        end
        checkOutput("w1_inflight", 32'(inflight), 32'd1);
        checkOutput("w1_ready", 32'(s_ready), 32'd1);
        applyStimulus(1'b1, 16'd9, 1'b0, '0);
        checkOutput("f3_start", 32'(fft_start), 32'd1);
        checkOutput("f3_real0", 32'(fft_real), 32'd9);
        checkOutput("f3_inflight", 32'(inflight), 32'd2);
        checkOutput("w1_closed", 32'(m_valid), 32'd0);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b1, DW'(9 + i), 1'b0, '0);
            checkOutput("f3_real", 32'(fft_real), 32'(9 + i));
            checkOutput("f3_over", 32'(fft_over), 32'(i == 7));
        end
        applyStimulus(1'b0, '0, 1'b0, '0);
        applyStimulus(1'b0, '0, 1'b0, '0);

        // Scenario 5a: second pipe_start inside an active window
        $display("[TB] scenario 5: overlap");
        applyStimulus(1'b0, '0, 1'b1, '0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, '0, 1'b0, DW'(k));
            checkOutput("w2_index", 32'(m_index), 32'(brev_tab[k]));
        end
        checkOutput("w2_no_overlap_yet", 32'(overlap_err), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 16'd3);
        checkOutput("w2_overlap", 32'(overlap_err), 32'd1);
        checkOutput("w2_restart_gap", 32'(m_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, '0, 1'b0, DW'(k + 16));
            checkOutput("w3_real", 32'(m_real), 32'(k + 16));
            checkOutput("w3_index", 32'(m_index), 32'(brev_tab[k]));
            checkOutput("w3_first", 32'(m_first), 32'(k == 0));
            checkOutput("w3_last", 32'(m_last), 32'(k == 7));
        end
        checkOutput("w3_overlap_sticky", 32'(overlap_err), 32'd1);
        checkOutput("w3_inflight", 32'(inflight), 32'd1);

        // Scenario 5b: fft_start and m_last in the same cycle
        applyStimulus(1'b0, '0, 1'b1, '0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b0, '0, 1'b0, DW'(k));
        end
        applyStimulus(1'b1, 16'h21, 1'b0, 16'd7);
        checkOutput("same_m_last", 32'(m_last), 32'd1);
        checkOutput("same_fft_start", 32'(fft_start), 32'd1);
        checkOutput("same_inflight", 32'(inflight), 32'd1);

        // Scenario 6: reset at cnt=5 of a running frame
        $display("[TB] scenario 6: mid-frame reset");
        for (int i = 2; i <= 5; i++) begin
            applyStimulus(1'b1, DW'(16'h20 + i), 1'b0, '0);
        end
        checkOutput("f4_real4", 32'(fft_real), 32'h25);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h26, 1'b0, '0);
        checkOutput("mrst_real", 32'(fft_real), 32'd0);
        checkOutput("mrst_over", 32'(fft_over), 32'd0);
        checkOutput("mrst_inflight", 32'(inflight), 32'd0);
        checkOutput("mrst_overlap", 32'(overlap_err), 32'd0);
        checkOutput("mrst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("mrst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b0, '0);
            checkOutput("abandoned_over", 32'(fft_over), 32'd0);
        end
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0, '0);
            checkOutput("f5_real", 32'(fft_real), 32'(i));
            checkOutput("f5_start", 32'(fft_start), 32'(i == 1));
            checkOutput("f5_over", 32'(fft_over), 32'(i == 8));
        end
        checkOutput("f5_inflight", 32'(inflight), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
